// File: rtl/mips_pkg.sv
// Shared datapath definitions: default register-file geometry, the hardwired
// zero index, and slice helpers for packed multi-port buses.
`ifndef MIPS_PKG_SV
`define MIPS_PKG_SV

// Port p of a packed bus whose fields are w bits wide.
`define RF_ADDR_SLICE(p, w) ((p) * (w)) +: (w)
`define RF_DATA_SLICE(p, w) ((p) * (w)) +: (w)

package mips_pkg;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int ZERO_IDX     = 0;
endpackage

`endif

// File: rtl/regfile_rd_port.sv
// One registered read port: zero-register / write-bypass / array selection
// followed by the read data and valid flops.
module regfile_rd_port
    import mips_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] regs [NUM_REGS],
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);

    logic [DATA_W-1:0] sel_data;

    // Zero register wins over bypass so a dropped write never leaks through.
    always_comb begin
        sel_data = regs[rd_addr];
        if (ZERO_REG && (rd_addr == ZERO_A)) begin
            sel_data = '0;
        end else if (BYPASS && wr_en && (wr_addr == rd_addr)) begin
            sel_data = wr_data;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= sel_data;
            end
        end
    end

endmodule

// File: rtl/regfile_bypass.sv
// Parametrised register file: NUM_RD registered read ports, one synchronous
// write port, optional hardwired zero register and write-to-read bypass.
module regfile_bypass
    import mips_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ack
);

    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);

    // Strobe protocol: there is no back-pressure. A read issued with rd_en[p]
    // in cycle n yields rd_valid[p]=1 with its data in cycle n+1; a write with
    // wr_en in cycle n raises wr_ack in cycle n+1 only if it was committed.
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_commit;

    assign wr_commit = wr_en && !(ZERO_REG && (wr_addr == ZERO_A));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wr_ack <= 1'b0;
        end else begin
            if (wr_commit) begin
                regs[wr_addr] <= wr_data;
            end
            wr_ack <= wr_commit;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .CLK      (CLK),
            .RESET    (RESET),
            .rd_en    (rd_en[p]),
            .rd_addr  (rd_addr[`RF_ADDR_SLICE(p, ADDR_W)]),
            .regs     (regs),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .rd_data  (rd_data[`RF_DATA_SLICE(p, DATA_W)]),
            .rd_valid (rd_valid[p])
        );
    end

endmodule

// File: tb/tb_regfile_bypass.sv
// Bench for regfile_bypass: three configurations driven in lockstep, a
// scoreboard queue per instance popped by a negedge monitor, and a final report.
module tb_regfile_bypass;

    // inst0: 32b x32, 2 ports, zero+bypass; inst1: 16b x8, 3 ports, neither;
    // inst2: 64b x64, 4 ports, zero+bypass.
    localparam int NRD [3] = '{2, 3, 4};
    localparam int NR  [3] = '{32, 8, 64};
    localparam int DW  [3] = '{32, 16, 64};
    localparam bit ZR  [3] = '{1'b1, 1'b0, 1'b1};
    localparam bit BP  [3] = '{1'b1, 1'b0, 1'b1};

    typedef struct packed {
        logic [1:0]  port;
        logic [63:0] data;
    } sb_t;

    logic CLK;
    logic RESET;

    logic [3:0]  en  [3];
    logic [5:0]  ad  [3][4];
    logic        wen [3];
    logic [5:0]  wad [3];
    logic [63:0] wd  [3];

    logic [63:0] rdat [3][4];
    logic [3:0]  rval [3];
    logic        wack [3];

    logic [63:0] model [3][64];
    sb_t         exp_q [3][$];

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- DUT instances ----------------
    logic [1:0]  d0_rd_en;   logic [9:0]   d0_rd_addr; logic [63:0]  d0_rd_data;
    logic [1:0]  d0_rd_valid; logic [4:0]  d0_wr_addr; logic [31:0]  d0_wr_data; logic d0_wr_ack;
    logic [2:0]  d1_rd_en;   logic [8:0]   d1_rd_addr; logic [47:0]  d1_rd_data;
    logic [2:0]  d1_rd_valid; logic [2:0]  d1_wr_addr; logic [15:0]  d1_wr_data; logic d1_wr_ack;
    logic [3:0]  d2_rd_en;   logic [23:0]  d2_rd_addr; logic [255:0] d2_rd_data;
    logic [3:0]  d2_rd_valid; logic [5:0]  d2_wr_addr; logic [63:0]  d2_wr_data; logic d2_wr_ack;

    always_comb begin
        d0_rd_en   = en[0][1:0];
        d0_rd_addr = {ad[0][1][4:0], ad[0][0][4:0]};
        d0_wr_addr = wad[0][4:0];
        d0_wr_data = wd[0][31:0];
        d1_rd_en   = en[1][2:0];
        d1_rd_addr = {ad[1][2][2:0], ad[1][1][2:0], ad[1][0][2:0]};
        d1_wr_addr = wad[1][2:0];
        d1_wr_data = wd[1][15:0];
        d2_rd_en   = en[2];
        d2_rd_addr = {ad[2][3], ad[2][2], ad[2][1], ad[2][0]};
        d2_wr_addr = wad[2];
        d2_wr_data = wd[2];
    end

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            rdat[0][p] = (p < 2) ? {32'b0, d0_rd_data[p*32 +: 32]} : 64'b0;
            rdat[1][p] = (p < 3) ? {48'b0, d1_rd_data[p*16 +: 16]} : 64'b0;
            rdat[2][p] = d2_rd_data[p*64 +: 64];
        end
        rval[0] = {2'b0, d0_rd_valid};
        rval[1] = {1'b0, d1_rd_valid};
        rval[2] = d2_rd_valid;
        wack[0] = d0_wr_ack;
        wack[1] = d1_wr_ack;
        wack[2] = d2_wr_ack;
    end

    regfile_bypass #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut0 (
        .CLK(CLK), .RESET(RESET), .rd_en(d0_rd_en), .rd_addr(d0_rd_addr), .rd_data(d0_rd_data),
        .rd_valid(d0_rd_valid), .wr_en(wen[0]), .wr_addr(d0_wr_addr), .wr_data(d0_wr_data),
        .wr_ack(d0_wr_ack));

    regfile_bypass #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(3), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .rd_en(d1_rd_en), .rd_addr(d1_rd_addr), .rd_data(d1_rd_data),
        .rd_valid(d1_rd_valid), .wr_en(wen[1]), .wr_addr(d1_wr_addr), .wr_data(d1_wr_data),
        .wr_ack(d1_wr_ack));

    regfile_bypass #(.DATA_W(64), .NUM_REGS(64), .NUM_RD(4), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut2 (
        .CLK(CLK), .RESET(RESET), .rd_en(d2_rd_en), .rd_addr(d2_rd_addr), .rd_data(d2_rd_data),
        .rd_valid(d2_rd_valid), .wr_en(wen[2]), .wr_addr(d2_wr_addr), .wr_data(d2_wr_data),
        .wr_ack(d2_wr_ack));

    // ---------------- helpers ----------------
    function automatic logic [63:0] dmask(int i);
        return (DW[i] == 64) ? {64{1'b1}} : ((64'd1 << DW[i]) - 64'd1);
    endfunction

    task automatic check(string name, int inst, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s inst%0d @%0t: got %h expected %h", name, inst, $time, act, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 3; i++) begin
            en[i]  = '0;
            wen[i] = 1'b0;
            wad[i] = '0;
            wd[i]  = '0;
            for (int p = 0; p < 4; p++) ad[i][p] = '0;
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            exp_q[i].delete();
            for (int r = 0; r < 64; r++) model[i][r] = '0;
        end
    endtask

    // ---------------- driver ----------------
    // Issues the inputs currently set, pushes the expected read results, then
    // checks this cycle's wr_ack and rd_valid just after the edge.
    task automatic tick();
        sb_t         e;
        logic [63:0] m;
        logic [63:0] v;
        logic [5:0]  a;
        logic        exp_ack [3];
        logic [3:0]  exp_val [3];
        for (int i = 0; i < 3; i++) begin
            m          = dmask(i);
            exp_val[i] = en[i];
            exp_ack[i] = wen[i] && !(ZR[i] && (wad[i] == 6'd0));
            for (int p = 0; p < NRD[i]; p++) begin
                if (en[i][p]) begin
                    a = ad[i][p];
                    if (ZR[i] && (a == 6'd0))                  v = '0;
                    else if (BP[i] && wen[i] && (wad[i] == a)) v = wd[i] & m;
                    else                                       v = model[i][a];
                    e.port = 2'(p);
                    e.data = v;
                    exp_q[i].push_back(e);
                end
            end
        end
        @(posedge CLK);
        for (int i = 0; i < 3; i++) begin
            if (exp_ack[i]) model[i][wad[i]] = wd[i] & dmask(i);
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            check("wr_ack", i, 64'(wack[i]), 64'(exp_ack[i]));
            check("rd_valid", i, 64'(rval[i]), 64'(exp_val[i]));
        end
        clear_inputs();
    endtask

    // Called one time unit after an edge; RESET high for 7 units, released
    // before the next edge. Any write set up for that cycle is abandoned.
    task automatic pulse_reset(bit chk);
        #1;
        RESET = 1'b1;
        clear_inputs();
        #1;
        if (chk) begin
            for (int i = 0; i < 3; i++) begin
                for (int p = 0; p < NRD[i]; p++) check("rst_rd_data", i, rdat[i][p], 64'h0);
                check("rst_rd_valid", i, 64'(rval[i]), 64'h0);
                check("rst_wr_ack", i, 64'(wack[i]), 64'h0);
            end
        end
        #6;
        RESET = 1'b0;
        clear_model();
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge CLK) begin : monitor
        sb_t e;
        if (!RESET) begin
            for (int i = 0; i < 3; i++) begin
                for (int p = 0; p < NRD[i]; p++) begin
                    if (rval[i][p]) begin
                        if (exp_q[i].size() == 0) begin
                            check("unexpected_valid", i, 64'(p), 64'hFFFF);
                        end else begin
                            e = exp_q[i].pop_front();
                            check("sb_port", i, 64'(p), 64'(e.port));
                            check("sb_rd_data", i, rdat[i][p], e.data);
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        RESET = 1'b0;
        clear_inputs();
        clear_model();
        #1;
        RESET = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("init_rd_valid", i, 64'(rval[i]), 64'h0);
            check("init_wr_ack", i, 64'(wack[i]), 64'h0);
            check("init_rd_data0", i, rdat[i][0], 64'h0);
        end
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        // write then read
        wen[0] = 1'b1; wad[0] = 6'd5; wd[0] = 64'hDEADBEEF;
        tick();
        check("wr_ack_after_write", 0, 64'(wack[0]), 64'h1);
        en[0] = 4'b0001; ad[0][0] = 6'd5;
        tick();
        check("read_reg5", 0, rdat[0][0], 64'hDEADBEEF);
        check("read_reg5_valid", 0, 64'(rval[0][0]), 64'h1);

        // asynchronous reset between edges, outputs must clear at once
        pulse_reset(1'b1);

        // every register reads zero after reset
        for (int a = 1; a < 32; a += 2) begin
            en[0] = (a < 31) ? 4'b0011 : 4'b0001;
            ad[0][0] = 6'(a);
            ad[0][1] = 6'(a + 1);
            tick();
            check("post_reset_zero", 0, rdat[0][0], 64'h0);
        end

        // same-cycle bypass on two ports (inst0) vs. no bypass on three (inst1)
        wen[0] = 1'b1; wad[0] = 6'd9; wd[0] = 64'h1234;
        en[0] = 4'b0011; ad[0][0] = 6'd9; ad[0][1] = 6'd9;
        wen[1] = 1'b1; wad[1] = 6'd5; wd[1] = 64'h1234;
        en[1] = 4'b0111; ad[1][0] = 6'd5; ad[1][1] = 6'd5; ad[1][2] = 6'd5;
        tick();
        check("bypass_p0", 0, rdat[0][0], 64'h1234);
        check("bypass_p1", 0, rdat[0][1], 64'h1234);
        check("nobypass_p0", 1, rdat[1][0], 64'h0);
        check("nobypass_p2", 1, rdat[1][2], 64'h0);
        en[1] = 4'b0111; ad[1][0] = 6'd5; ad[1][1] = 6'd5; ad[1][2] = 6'd5;
        tick();
        check("nobypass_next_p1", 1, rdat[1][1], 64'h1234);

        // zero register: dropped on inst0, ordinary register on inst1
        wen[0] = 1'b1; wad[0] = 6'd0; wd[0] = 64'hFFFFFFFF;
        en[0] = 4'b0011; ad[0][0] = 6'd0; ad[0][1] = 6'd0;
        wen[1] = 1'b1; wad[1] = 6'd0; wd[1] = 64'hFFFF;
        tick();
        check("zero_wr_ack", 0, 64'(wack[0]), 64'h0);
        check("zero_same_cycle", 0, rdat[0][1], 64'h0);
        check("nozero_wr_ack", 1, 64'(wack[1]), 64'h1);
        en[0] = 4'b0001; ad[0][0] = 6'd0;
        en[1] = 4'b0001; ad[1][0] = 6'd0;
        tick();
        check("zero_later", 0, rdat[0][0], 64'h0);
        check("nozero_read", 1, rdat[1][0], 64'hFFFF);

        // hold: read data is not refreshed by later writes while rd_en is low
        wen[0] = 1'b1; wad[0] = 6'd3; wd[0] = 64'd7;
        tick();
        en[0] = 4'b0001; ad[0][0] = 6'd3;
        tick();
        check("hold_read7", 0, rdat[0][0], 64'd7);
        wen[0] = 1'b1; wad[0] = 6'd3; wd[0] = 64'd8;
        tick();
        check("hold_data", 0, rdat[0][0], 64'd7);
        check("hold_valid", 0, 64'(rval[0][0]), 64'h0);
        tick();
        check("hold_data_idle", 0, rdat[0][0], 64'd7);

        // reset during an in-flight write to reg4
        wen[0] = 1'b1; wad[0] = 6'd4; wd[0] = 64'd9;
        pulse_reset(1'b0);
        en[0] = 4'b0011; ad[0][0] = 6'd4; ad[0][1] = 6'd3;
        tick();
        check("aborted_write", 0, rdat[0][0], 64'h0);
        check("reset_cleared_reg3", 0, rdat[0][1], 64'h0);

        // random streams on all configurations against the model
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 3; i++) begin
                en[i]  = 4'($urandom_range(0, (1 << NRD[i]) - 1));
                wen[i] = 1'($urandom_range(0, 1));
                wad[i] = 6'($urandom_range(0, NR[i] - 1));
                wd[i]  = {$urandom, $urandom} & dmask(i);
                for (int p = 0; p < NRD[i]; p++) ad[i][p] = 6'($urandom_range(0, NR[i] - 1));
                if ($urandom_range(0, 3) == 0) ad[i][0] = wad[i];
                if ($urandom_range(0, 7) == 0) ad[i][NRD[i] - 1] = ad[i][0];
            end
            tick();
        end

        tick();
        @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) check("sb_drained", i, 64'(exp_q[i].size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
